trigger_capture: RTL

Sink for the trigger block's annotated output stream (tvalid/tready/tevent/tdata). It stores samples in a circular buffer with a programmable pre-trigger depth and post-trigger length. Once capture completes, it replays the captured window oldest-first on an AXI-stream-like readout port with tlast. It is configured over the same write-only system bus as the trigger block and sits between trigger and the host readout path.

---
 rtl/trigger_pkg.sv | 25 ++
 rtl/trigger_capture_ram.sv | 30 +++
 rtl/trigger_capture.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_pkg.sv
// Definitions shared by the trigger block and its capture sink: event tags,
// capture register addresses and the capture FSM state type.
package trigger_pkg;

    localparam logic [1:0] EVT_NONE    = 2'b00;
    localparam logic [1:0] EVT_START   = 2'b01;
    localparam logic [1:0] EVT_TRIGGER = 2'b10;
    localparam logic [1:0] EVT_ABORT   = 2'b11;

    localparam int CAP_CTRL = 0;
    localparam int CAP_PRE  = 1;
    localparam int CAP_POST = 2;

    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_ABORT_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_PRE   = 3'd2,
        ST_POST  = 3'd3,
        ST_READ  = 3'd4
    } cap_state_t;

endpackage

// File: rtl/trigger_capture_ram.sv
// Simple dual-port sample buffer: one write port, one read port with
// registered read data (maps onto block RAM).
module trigger_capture_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/trigger_capture.sv
// Circular-buffer capture of the annotated trigger stream with programmable
// pre/post window, replayed oldest-first on a ready/valid port with tlast.
module trigger_capture
    import trigger_pkg::*;
#(
    parameter int BDW = 32,
    parameter int BAW = 6,
    parameter int SDW = 32,
    parameter int MAW = 10
) (
    input  logic           clk,
    input  logic           rst,
    output logic           bus_wready,
    input  logic           bus_wvalid,
    input  logic [BAW-1:0] bus_waddr,
    input  logic [BDW-1:0] bus_wdata,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic [1:0]     sti_tevent,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic           sto_tlast,
    output logic [SDW-1:0] sto_tdata,
    output logic [2:0]     sts_state,
    output logic           sts_done
);

    localparam int DEPTH = 1 << MAW;

    cap_state_t     state_reg;
    logic [MAW-1:0] pre_cfg_reg, pre_reg, fill_reg, wptr_reg, rd_addr_reg;
    logic [MAW:0]   post_cfg_reg, eff_post_reg, post_cnt_reg, rd_left_reg;
    logic           rd_pend_reg, rd_pend_last_reg;
    logic [1:0]     ob_cnt_reg;
    logic [SDW-1:0] ob0_data_reg, ob1_data_reg;
    logic           ob0_last_reg, ob1_last_reg;
    logic           done_reg;

    logic           wr_ctrl, ctrl_arm, ctrl_abort, xfer, capturing, abort_now, wr_en;
    logic [MAW:0]   post_min, eff_post_calc, read_len;
    logic [MAW+1:0] post_sum;
    logic [MAW-1:0] fill_sat, read_base;
    logic           pop, push, issue, last_pop;
    logic [1:0]     credits;
    logic [SDW-1:0] ram_rdata;
    logic           unused_wdata;

    assign bus_wready   = 1'b1;
    assign unused_wdata = ^bus_wdata[BDW-1:MAW+1];

    assign wr_ctrl    = bus_wvalid && (bus_waddr == BAW'(CAP_CTRL));
    assign ctrl_abort = wr_ctrl && bus_wdata[CTRL_ABORT_BIT];
    assign ctrl_arm   = wr_ctrl && bus_wdata[CTRL_ARM_BIT] && !bus_wdata[CTRL_ABORT_BIT];

    assign sti_tready = (state_reg != ST_READ);
    assign xfer       = sti_tvalid && sti_tready;
    assign capturing  = (state_reg == ST_ARMED) || (state_reg == ST_PRE) || (state_reg == ST_POST);
    assign abort_now  = capturing && (ctrl_abort || (xfer && sti_tevent == EVT_ABORT));
    assign wr_en      = xfer && !abort_now &&
                        ((state_reg == ST_ARMED && sti_tevent == EVT_START) ||
                         state_reg == ST_PRE || state_reg == ST_POST);

    // Post length is at least one sample and never pushes the window past the buffer depth.
    assign post_min      = (post_cfg_reg == '0) ? (MAW+1)'(1) : post_cfg_reg;
    assign post_sum      = (MAW+2)'(pre_cfg_reg) + (MAW+2)'(post_min);
    assign eff_post_calc = (post_sum > (MAW+2)'(DEPTH)) ?
                           (MAW+1)'(DEPTH) - (MAW+1)'(pre_cfg_reg) : post_min;

    assign fill_sat  = (fill_reg < pre_reg) ? fill_reg + MAW'(1) : fill_reg;
    assign read_len  = (MAW+1)'(fill_reg) + eff_post_reg;
    assign read_base = wptr_reg + MAW'(1) - read_len[MAW-1:0];

    // Reads are issued only when the skid pair can absorb everything in flight.
    assign pop      = sto_tvalid && sto_tready;
    assign push     = rd_pend_reg;
    assign credits  = ob_cnt_reg + {1'b0, rd_pend_reg} - {1'b0, pop};
    assign issue    = (state_reg == ST_READ) && (rd_left_reg != '0) && (credits < 2'd2);
    assign last_pop = pop && ob0_last_reg;

    assign sto_tvalid = (ob_cnt_reg != 2'd0);
    assign sto_tlast  = sto_tvalid && ob0_last_reg;
    assign sto_tdata  = ob0_data_reg;
    assign sts_state  = state_reg;
    assign sts_done   = done_reg;

    trigger_capture_ram #(
        .AW(MAW),
        .DW(SDW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr_reg),
        .wdata (sti_tdata),
        .re    (issue),
        .raddr (rd_addr_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            pre_cfg_reg      <= '0;
            post_cfg_reg     <= '0;
            pre_reg          <= '0;
            eff_post_reg     <= '0;
            post_cnt_reg     <= '0;
            fill_reg         <= '0;
            wptr_reg         <= '0;
            rd_addr_reg      <= '0;
            rd_left_reg      <= '0;
            rd_pend_reg      <= 1'b0;
            rd_pend_last_reg <= 1'b0;
            ob_cnt_reg       <= 2'd0;
            ob0_data_reg     <= '0;
            ob1_data_reg     <= '0;
            ob0_last_reg     <= 1'b0;
            ob1_last_reg     <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (bus_wvalid && bus_waddr == BAW'(CAP_PRE)) begin
                pre_cfg_reg <= bus_wdata[MAW-1:0];
            end
            if (bus_wvalid && bus_waddr == BAW'(CAP_POST)) begin
                post_cfg_reg <= bus_wdata[MAW:0];
            end
            if (wr_en) begin
                wptr_reg <= wptr_reg + MAW'(1);
            end

            rd_pend_reg <= issue;
            if (issue) begin
                rd_addr_reg      <= rd_addr_reg + MAW'(1);
                rd_left_reg      <= rd_left_reg - (MAW+1)'(1);
                rd_pend_last_reg <= (rd_left_reg == (MAW+1)'(1));
            end

            // Output skid pair: slot 0 drives the port, slot 1 catches data under stall.
            if (push && !pop) begin
                if (ob_cnt_reg == 2'd0) begin
                    ob0_data_reg <= ram_rdata;
                    ob0_last_reg <= rd_pend_last_reg;
                end else begin
                    ob1_data_reg <= ram_rdata;
                    ob1_last_reg <= rd_pend_last_reg;
                end
                ob_cnt_reg <= ob_cnt_reg + 2'd1;
            end else if (pop && !push) begin
                ob0_data_reg <= ob1_data_reg;
                ob0_last_reg <= ob1_last_reg;
                ob_cnt_reg   <= ob_cnt_reg - 2'd1;
            end else if (pop && push) begin
                if (ob_cnt_reg == 2'd1) begin
                    ob0_data_reg <= ram_rdata;
                    ob0_last_reg <= rd_pend_last_reg;
                end else begin
                    ob0_data_reg <= ob1_data_reg;
                    ob0_last_reg <= ob1_last_reg;
                    ob1_data_reg <= ram_rdata;
                    ob1_last_reg <= rd_pend_last_reg;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (ctrl_arm) begin
                        pre_reg      <= pre_cfg_reg;
                        eff_post_reg <= eff_post_calc;
                        fill_reg     <= '0;
                        state_reg    <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (abort_now) begin
                        state_reg <= ST_IDLE;
                    end else if (wr_en) begin
                        fill_reg  <= fill_sat;
                        state_reg <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (abort_now) begin
                        state_reg <= ST_IDLE;
                    end else if (xfer) begin
                        if (sti_tevent == EVT_TRIGGER) begin
                            post_cnt_reg <= eff_post_reg - (MAW+1)'(1);
                            if (eff_post_reg == (MAW+1)'(1)) begin
                                rd_addr_reg <= read_base;
                                rd_left_reg <= read_len;
                                state_reg   <= ST_READ;
                            end else begin
                                state_reg <= ST_POST;
                            end
                        end else begin
                            fill_reg <= fill_sat;
                        end
                    end
                end
                ST_POST: begin
                    if (abort_now) begin
                        state_reg <= ST_IDLE;
                    end else if (xfer) begin
                        post_cnt_reg <= post_cnt_reg - (MAW+1)'(1);
                        if (post_cnt_reg == (MAW+1)'(1)) begin
                            rd_addr_reg <= read_base;
                            rd_left_reg <= read_len;
                            state_reg   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (ctrl_abort) begin
                        ob_cnt_reg  <= 2'd0;
                        rd_pend_reg <= 1'b0;
                        rd_left_reg <= '0;
                        state_reg   <= ST_IDLE;
                    end else if (last_pop) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
